// File: rtl/board_input_conditioner.sv
// Synchronises and debounces the board switches/keys and derives register index, enable, half select and step pulses.
// Raw change to stable output takes 2+DEBOUNCE_CYCLES edges; derived outputs follow one edge later.
module board_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sw_sel_raw,
  input  logic       sw_en_raw,
  input  logic       key_half_raw,
  input  logic       key_step_raw,
  output logic [4:0] sel_idx,
  output logic       idx_changed,
  output logic       en_clean,
  output logic       half_sel,
  output logic       step_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  // Bit order {key_step, key_half, sw_en, sw_sel[4:0]}; keys idle high.
  localparam logic [7:0] IDLE_LVL = 8'hC0;

  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("REPEAT_PERIOD must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} step_state_t;

  logic [7:0]    raw;
  logic [7:0]    sync1_q, sync2_q, stab_q, stab_d;
  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];

  assign raw = {key_step_raw, key_half_raw, sw_en_raw, sw_sel_raw};

  always_comb begin
    stab_d = stab_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == DB_LAST) stab_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      stab_q  <= IDLE_LVL;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [4:0]  sel_prev_q;
  logic        half_prev_q, step_prev_q;
  logic        idx_chg_q, half_q, pulse_q, pulse_d;
  logic        half_press, step_press, step_released;
  step_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  // Press = stable key falling edge; release never counts.
  assign half_press    = half_prev_q & ~stab_q[6];
  assign step_press    = step_prev_q & ~stab_q[7];
  assign step_released = stab_q[7];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_press) begin
          pulse_d = 1'b1;
          timer_d = '0;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (step_released) begin
          state_d = IDLE;
        end else if (timer_q == ((state_q == DELAY) ? DLY_LAST : PER_LAST)) begin
          pulse_d = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_prev_q  <= '0;
      half_prev_q <= 1'b1;
      step_prev_q <= 1'b1;
      idx_chg_q   <= 1'b0;
      half_q      <= 1'b0;
      pulse_q     <= 1'b0;
      state_q     <= IDLE;
      timer_q     <= '0;
    end else begin
      sel_prev_q  <= stab_q[4:0];
      half_prev_q <= stab_q[6];
      step_prev_q <= stab_q[7];
      idx_chg_q   <= (stab_q[4:0] != sel_prev_q);
      half_q      <= half_q ^ half_press;
      pulse_q     <= pulse_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
    end
  end

  assign sel_idx     = stab_q[4:0];
  assign en_clean    = stab_q[5];
  assign idx_changed = idx_chg_q;
  assign half_sel    = half_q;
  assign step_pulse  = pulse_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench for board_input_conditioner with short debounce/repeat parameters.
module tb_board_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sw_sel_raw;
  logic       sw_en_raw, key_half_raw, key_step_raw;
  logic [4:0] sel_idx;
  logic       idx_changed, en_clean, half_sel, step_pulse;

  board_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_sel_raw(sw_sel_raw),
    .sw_en_raw(sw_en_raw),
    .key_half_raw(key_half_raw),
    .key_step_raw(key_step_raw),
    .sel_idx(sel_idx),
    .idx_changed(idx_changed),
    .en_clean(en_clean),
    .half_sel(half_sel),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bit order {step, half, en, sel[4:0]}.
  logic [7:0] m_s1, m_s2, m_st;
  int         m_cnt [8];
  logic [4:0] m_sel_prev;
  logic       m_half_prev, m_step_prev, m_idxch, m_half, m_pulse;
  int         m_state, m_timer;

  task automatic model_reset();
    m_s1 = 8'hC0; m_s2 = 8'hC0; m_st = 8'hC0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_sel_prev = '0; m_half_prev = 1'b1; m_step_prev = 1'b1;
    m_idxch = 1'b0; m_half = 1'b0; m_pulse = 1'b0;
    m_state = 0; m_timer = 0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    logic [7:0] st;
    st = m_st;
    m_idxch = (st[4:0] != m_sel_prev);
    if (m_half_prev && !st[6]) m_half = ~m_half;
    m_pulse = 1'b0;
    case (m_state)
      0: if (m_step_prev && !st[7]) begin m_pulse = 1'b1; m_timer = 0; m_state = 1; end
      1, 2: begin
        if (st[7]) m_state = 0;
        else if (m_timer == ((m_state == 1) ? RD - 1 : RP - 1)) begin
          m_pulse = 1'b1; m_timer = 0; m_state = 2;
        end else m_timer++;
      end
      default: m_state = 0;
    endcase
    m_sel_prev = st[4:0]; m_half_prev = st[6]; m_step_prev = st[7];
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] == m_st[i]) m_cnt[i] = 0;
      else if (m_cnt[i] == D - 1) begin m_st[i] = m_s2[i]; m_cnt[i] = 0; end
      else m_cnt[i]++;
    end
    m_s2 = m_s1;
    m_s1 = r;
  endtask

  logic [8:0] exp_q [$];
  string      scn;
  int         edge_n;
  int         ev_idx [$];
  int         ev_en [$];
  int         ev_half [$];
  int         ev_step [$];
  logic       prev_en, prev_half;

  task automatic begin_scn(input string name);
    scn = name;
    edge_n = -1;
    ev_idx.delete(); ev_en.delete(); ev_half.delete(); ev_step.delete();
    prev_en = m_st[5];
    prev_half = m_half;
  endtask

  // Drive-side pushes the model's prediction; the post-edge sample pops and compares.
  task automatic tick();
    logic [8:0] e, got;
    if (reset) model_edge({key_step_raw, key_half_raw, sw_en_raw, sw_sel_raw});
    else       model_reset();
    exp_q.push_back({m_st[4:0], m_idxch, m_st[5], m_half, m_pulse});
    @(posedge clk);
    #1;
    edge_n++;
    got = {sel_idx, idx_changed, en_clean, half_sel, step_pulse};
    e = exp_q.pop_front();
    chk(scn, {23'd0, got}, {23'd0, e});
    if (idx_changed) ev_idx.push_back(edge_n);
    if (step_pulse) ev_step.push_back(edge_n);
    if (en_clean != prev_en) ev_en.push_back(edge_n);
    if (half_sel != prev_half) ev_half.push_back(edge_n);
    prev_en = en_clean;
    prev_half = half_sel;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int exp_step [8];
    exp_step = '{6, 16, 19, 22, 25, 28, 31, 34};
    reset = 1'b0;
    sw_sel_raw = '0; sw_en_raw = 1'b0; key_half_raw = 1'b1; key_step_raw = 1'b1;
    model_reset();
    begin_scn("reset");
    #2;
    chk("reset_outs", {27'd0, sel_idx, idx_changed, en_clean, half_sel, step_pulse}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      {key_step_raw, key_half_raw, sw_en_raw, sw_sel_raw} = 8'($urandom);
      tick();
    end
    sw_sel_raw = '0; sw_en_raw = 1'b0; key_half_raw = 1'b1; key_step_raw = 1'b1;
    reset = 1'b1;
    tick();
    chk("reset_first_edge", {27'd0, sel_idx, idx_changed, en_clean, half_sel, step_pulse}, 32'd0);
    ticks(6);

    begin_scn("clean_switch");
    sw_sel_raw = 5'b10110;
    ticks(5);
    chk("sel_before_edge5", sel_idx, 0);
    tick();
    chk("sel_at_edge5", sel_idx, 22);
    ticks(6);
    chk("idx_chg_count", ev_idx.size(), 1);
    if (ev_idx.size() == 1) chk("idx_chg_edge", ev_idx[0], 6);

    begin_scn("staggered_bits");
    sw_sel_raw = 5'b10111;
    ticks(2);
    sw_sel_raw = 5'b10101;
    ticks(10);
    chk("stagger_count", ev_idx.size(), 2);
    if (ev_idx.size() == 2) begin
      chk("stagger_edge0", ev_idx[0], 6);
      chk("stagger_edge1", ev_idx[1], 8);
    end
    chk("stagger_sel", sel_idx, 5'b10101);

    begin_scn("en_bounce");
    sw_en_raw = 1'b1; ticks(3);
    sw_en_raw = 1'b0; ticks(2);
    sw_en_raw = 1'b1; ticks(10);
    chk("en_change_count", ev_en.size(), 1);
    if (ev_en.size() == 1) chk("en_change_edge", ev_en[0], 10);
    chk("en_final", en_clean, 1);

    begin_scn("half_toggle");
    key_half_raw = 1'b0; ticks(8);
    key_half_raw = 1'b1; ticks(8);
    key_half_raw = 1'b0; ticks(8);
    key_half_raw = 1'b1; ticks(10);
    chk("half_toggle_count", ev_half.size(), 2);
    if (ev_half.size() == 2) begin
      chk("half_toggle0", ev_half[0], 6);
      chk("half_toggle1", ev_half[1], 22);
    end
    chk("half_final", half_sel, 0);

    begin_scn("step_repeat");
    key_step_raw = 1'b0; ticks(30);
    key_step_raw = 1'b1; ticks(15);
    chk("step_count", ev_step.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < ev_step.size()) chk($sformatf("step_edge%0d", i), ev_step[i], exp_step[i]);

    begin_scn("reset_mid_repeat");
    key_step_raw = 1'b0; ticks(20);
    chk("pulse_before_reset", step_pulse, 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("pulse_on_reset", step_pulse, 0);
    ticks(2);
    reset = 1'b1;
    begin_scn("after_reset");
    ticks(12);
    chk("fresh_step_count", ev_step.size(), 1);
    if (ev_step.size() == 1) chk("fresh_step_edge", ev_step[0], 6);
    key_step_raw = 1'b1; ticks(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
